calculator_ctrl: RTL and testbench

- Front-end controller for the 8-bit board calculator.
- Debounces the push button and latches func/num1/num2 on each press, then sequences a single-cycle or iterative 8-step operation.
- Publishes a held 32-bit cal_result plus busy/done/err status.
- Sits between the switch/button inputs and calculator_display, in the clk_g domain.

---
 rtl/calculator_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_calculator_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculator_ctrl.sv
// calculator_ctrl: debounced button front end and operation sequencer for the 8-bit board calculator.
// Define CAL_DIV_EN to build the iterative restoring divider for func 111; otherwise func 111 reports err.
module calculator_ctrl #(
    parameter int DEB_CYCLES = 200000,
    parameter int DEB_W      = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic [2:0]  func,
    input  logic [7:0]  num1,
    input  logic [7:0]  num2,
    output logic [31:0] cal_result,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // state  | meaning
    // IDLE   | waiting for a press; operands latched on press
    // LOAD   | single-cycle result computed, or iterative registers cleared
    // EXEC   | one shift-add / restoring-divide step per cycle, 8 steps
    // DONE   | done pulse; result and err were written on entry
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;

    logic             sync_1;
    logic             sync_2;
    logic             deb_level;
    logic             deb_prev;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;

    logic [2:0]       op_func;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [15:0]      acc;
    logic [2:0]       step;
    logic             iterative;

    logic [8:0]       sum9;
    logic [8:0]       diff9;
    logic [14:0]      shl15;
    logic [31:0]      single_res;
    logic [15:0]      mul_add;
    logic [15:0]      mul_acc;
    logic [31:0]      res_nxt;
    logic             err_nxt;

`ifdef CAL_DIV_EN
    logic [6:0]       shreg;
    logic [8:0]       div_trial;
    logic             div_ge;
    logic [7:0]       div_rem;
    logic [7:0]       div_quot;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync_1   <= button;
            sync_2   <= sync_1;
            deb_prev <= deb_level;
            if (sync_2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= sync_2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press = deb_level & ~deb_prev;

`ifdef CAL_DIV_EN
    assign iterative = (op_func[2:1] == 2'b11);
`else
    assign iterative = (op_func == 3'b110);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (press) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = iterative ? S_EXEC : S_DONE;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (step == 3'd7) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sum9  = {1'b0, op_a} + {1'b0, op_b};
    assign diff9 = {1'b0, op_a} - {1'b0, op_b};
    assign shl15 = {7'd0, op_a} << op_b[2:0];

    always_comb begin
        single_res = '0;
        case (op_func)
            3'b000:  single_res = {23'd0, sum9};
            3'b001:  single_res = {{23{diff9[8]}}, diff9};
            3'b010:  single_res = {24'd0, op_a & op_b};
            3'b011:  single_res = {24'd0, op_a | op_b};
            3'b100:  single_res = {24'd0, op_a ^ op_b};
            3'b101:  single_res = {17'd0, shl15};
            default: single_res = '0;
        endcase
    end

    // Multiplier bit 'step' selects whether num1 << step joins the product.
    assign mul_add = op_b[step] ? ({8'd0, op_a} << step) : 16'd0;
    assign mul_acc = acc + mul_add;

`ifdef CAL_DIV_EN
    // Restoring divide, dividend MSB first; acc[7:0] carries the partial remainder.
    assign div_trial = {acc[7:0], op_a[3'd7 - step]};
    assign div_ge    = (div_trial >= {1'b0, op_b});
    assign div_rem   = div_ge ? 8'(div_trial - {1'b0, op_b}) : div_trial[7:0];
    assign div_quot  = {shreg, div_ge};
`endif

    always_comb begin
        res_nxt = single_res;
        err_nxt = 1'b0;
        if (state == S_EXEC) begin
            res_nxt = {16'd0, mul_acc};
        end
`ifdef CAL_DIV_EN
        if (state == S_EXEC && op_func[0]) begin
            if (op_b == 8'd0) begin
                res_nxt = 32'hFFFF_FFFF;
                err_nxt = 1'b1;
            end else begin
                res_nxt = {8'd0, div_rem, 8'd0, div_quot};
            end
        end
`else
        if (op_func == 3'b111) begin
            res_nxt = '0;
            err_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_func    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            acc        <= '0;
            step       <= '0;
`ifdef CAL_DIV_EN
            shreg      <= '0;
`endif
            cal_result <= '0;
            err        <= 1'b0;
        end else begin
            if (state == S_IDLE && press) begin
                op_func <= func;
                op_a    <= num1;
                op_b    <= num2;
            end
            case (state)
                S_LOAD: begin
                    acc   <= '0;
                    step  <= '0;
`ifdef CAL_DIV_EN
                    shreg <= '0;
`endif
                end
                S_EXEC: begin
                    step <= step + 3'd1;
                    acc  <= mul_acc;
`ifdef CAL_DIV_EN
                    if (op_func[0]) begin
                        acc   <= {8'd0, div_rem};
                        shreg <= div_quot[6:0];
                    end
`endif
                end
                default: ;
            endcase
            // DONE always returns to IDLE, so this fires only on the entering edge.
            if (state_nxt == S_DONE) begin
                cal_result <= res_nxt;
                err        <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_calculator_ctrl.sv
// Self-checking bench for calculator_ctrl: directed scenarios plus randomized presses,
// every cycle compared against a press-window / arithmetic reference model.
module tb_calculator_ctrl;

    localparam int DEB = 4;

`ifdef CAL_DIV_EN
    localparam logic [31:0] DIV_RES  = 32'h0004_001C;
    localparam logic [31:0] DIV0_RES = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_ERR  = 32'd0;
    localparam int          DIV_LAT  = DEB + 12;
`else
    localparam logic [31:0] DIV_RES  = 32'd0;
    localparam logic [31:0] DIV0_RES = 32'd0;
    localparam logic [31:0] DIV_ERR  = 32'd1;
    localparam int          DIV_LAT  = DEB + 4;
`endif

    logic        clk;
    logic        rst;
    logic        button;
    logic [2:0]  func;
    logic [7:0]  num1;
    logic [7:0]  num2;
    logic [31:0] cal_result;
    logic        busy;
    logic        done;
    logic        err;

    calculator_ctrl #(.DEB_CYCLES(DEB), .DEB_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .func       (func),
        .num1       (num1),
        .num2       (num2),
        .cal_result (cal_result),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          busy_from;
    int          done_at;
    bit          m_level;
    logic [31:0] m_res;
    logic        m_err;
    logic [31:0] pend_res;
    logic        pend_err;
    bit          bhist[$];
    bit          syncq[$];
    int          done_seen;
    int          last_done_cyc;
    int          busy_cnt;
    int          start_cyc;
    int          d0;
    logic [2:0]  rf;
    logic [7:0]  ra;
    logic [7:0]  rb;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                   output int lat, output logic [31:0] res, output logic e);
        lat = 2;
        e   = 1'b0;
        res = 32'd0;
        case (f)
            3'd0: res = 32'(a) + 32'(b);
            3'd1: res = 32'(int'(a) - int'(b));
            3'd2: res = 32'(a & b);
            3'd3: res = 32'(a | b);
            3'd4: res = 32'(a ^ b);
            3'd5: res = 32'(a) << (b % 8);
            3'd6: begin
                lat = 10;
                res = 32'(a) * 32'(b);
            end
            default: begin
`ifdef CAL_DIV_EN
                lat = 10;
                if (b == 8'd0) begin
                    res = 32'hFFFF_FFFF;
                    e   = 1'b1;
                end else begin
                    res = (32'(a % b) << 16) | 32'(a / b);
                end
`else
                res = 32'd0;
                e   = 1'b1;
`endif
            end
        endcase
    endfunction

    task automatic model_reset();
        cyc       = 0;
        busy_from = 1 << 30;
        done_at   = -100;
        m_level   = 1'b0;
        m_res     = 32'd0;
        m_err     = 1'b0;
        bhist.delete();
        syncq.delete();
    endtask

    // Level flips once the last DEB synchronized samples (button two edges late) all disagree with it.
    task automatic model_edge();
        bit s;
        bit all_diff;
        int lat;
        cyc++;
        if (cyc == busy_from) begin
            ref_op(func, num1, num2, lat, pend_res, pend_err);
            done_at = cyc - 1 + lat;
        end
        if (cyc == done_at) begin
            m_res = pend_res;
            m_err = pend_err;
        end
        bhist.push_back(button);
        if (bhist.size() > 3) void'(bhist.pop_front());
        s = (bhist.size() == 3) ? bhist[0] : 1'b0;
        syncq.push_back(s);
        if (syncq.size() > DEB) void'(syncq.pop_front());
        all_diff = (syncq.size() == DEB);
        foreach (syncq[i]) if (syncq[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
            m_level = ~m_level;
            if (m_level && cyc > done_at) begin
                busy_from = cyc + 1;
                done_at   = cyc + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        if (done === 1'b1) begin
            done_seen++;
            last_done_cyc = cyc;
        end
        if (busy === 1'b1 && done !== 1'b1) busy_cnt++;
        check("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= done_at));
        check("done", 32'(done), 32'(cyc == done_at));
        check("cal_result", cal_result, m_res);
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic press_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                            input int hold, input int total);
        func      = f;
        num1      = a;
        num2      = b;
        start_cyc = cyc;
        d0        = done_seen;
        button    = 1'b1;
        repeat (hold) tick();
        button = 1'b0;
        repeat (total - hold) tick();
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        done_seen     = 0;
        last_done_cyc = -1;
        busy_cnt      = 0;
        rst           = 1'b1;
        button        = 1'b0;
        func          = 3'd0;
        num1          = 8'd0;
        num2          = 8'd0;
        model_reset();
        repeat (3) tick();
        #2 rst = 1'b0;
        repeat (2) tick();

        // reset and add with a long hold
        press_op(3'd0, 8'hFF, 8'h01, 10, 18);
        check("t1_dones", 32'(done_seen - d0), 32'd1);
        check("t1_res", cal_result, 32'h0000_0100);
        check("t1_err", 32'(err), 32'd0);
        check("t1_lat", 32'(last_done_cyc - start_cyc), 32'(DEB + 4));
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("t1_rst_res", cal_result, 32'd0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        check("t1_rst_done", 32'(done), 32'd0);
        check("t1_rst_err", 32'(err), 32'd0);
        repeat (2) tick();
        #2 rst = 1'b0;
        repeat (2) tick();

        // bounce is filtered, then a clean 6-cycle hold presses once
        func = 3'd2;
        num1 = 8'hF0;
        num2 = 8'h3C;
        d0   = done_seen;
        for (int i = 0; i < 10; i++) begin
            button = (i % 2 == 0);
            repeat (2) tick();
        end
        button = 1'b0;
        repeat (8) tick();
        check("t2_bounce_dones", 32'(done_seen - d0), 32'd0);
        start_cyc = cyc;
        button    = 1'b1;
        repeat (6) tick();
        button = 1'b0;
        repeat (10) tick();
        check("t2_press_dones", 32'(done_seen - d0), 32'd1);
        check("t2_res", cal_result, 32'h0000_0030);
        check("t2_lat", 32'(last_done_cyc - start_cyc), 32'(DEB + 4));

        // sub and mul
        press_op(3'd1, 8'd3, 8'd5, 6, 14);
        check("t3_sub_res", cal_result, 32'hFFFF_FFFE);
        busy_cnt = 0;
        press_op(3'd6, 8'hFF, 8'hFF, 6, 22);
        check("t3_mul_res", cal_result, 32'h0000_FE01);
        check("t3_mul_lat", 32'(last_done_cyc - start_cyc), 32'(DEB + 12));
        check("t3_mul_busy", 32'(busy_cnt), 32'd9);
        check("t3_mul_dones", 32'(done_seen - d0), 32'd1);

        // divide, divide by zero, then a clean add
        press_op(3'd7, 8'd200, 8'd7, 6, 22);
        check("t4_div_res", cal_result, DIV_RES);
        check("t4_div_err", 32'(err), DIV_ERR);
        check("t4_div_lat", 32'(last_done_cyc - start_cyc), 32'(DIV_LAT));
        press_op(3'd7, 8'h55, 8'd0, 6, 22);
        check("t4_div0_res", cal_result, DIV0_RES);
        check("t4_div0_err", 32'(err), 32'd1);
        check("t4_div0_lat", 32'(last_done_cyc - start_cyc), 32'(DIV_LAT));
        press_op(3'd0, 8'd1, 8'd1, 6, 16);
        check("t4_add_res", cal_result, 32'd2);
        check("t4_add_err", 32'(err), 32'd0);

        // second clean press during EXEC is dropped
        press_op(3'd6, 8'd12, 8'd13, 4, 8);
        func   = 3'd0;
        num1   = 8'd99;
        num2   = 8'd99;
        button = 1'b1;
        repeat (4) tick();
        button = 1'b0;
        repeat (3) tick();
        check("t5_hold_old", cal_result, 32'd2);
        repeat (14) tick();
        check("t5_dones", 32'(done_seen - d0), 32'd1);
        check("t5_res", cal_result, 32'd156);

        // reset during mul step 4
        press_op(3'd6, 8'hAB, 8'hCD, 4, 12);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_res", cal_result, 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        repeat (2) tick();
        #2 rst = 1'b0;
        repeat (16) tick();
        check("t6_no_done", 32'(done_seen - d0), 32'd0);
        check("t6_res", cal_result, 32'd0);

        // randomized presses, glitches and overlapping holds
        for (int i = 0; i < 30; i++) begin
            rf   = 3'($urandom_range(7, 0));
            ra   = 8'($urandom_range(255, 0));
            rb   = ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 0));
            func = rf;
            num1 = ra;
            num2 = rb;
            if ($urandom_range(3, 0) == 0) begin
                button = 1'b1;
                repeat ($urandom_range(2, 1)) tick();
                button = 1'b0;
                repeat (2) tick();
            end
            button = 1'b1;
            repeat ($urandom_range(DEB + 4, DEB)) tick();
            button = 1'b0;
            repeat ($urandom_range(16, 3)) tick();
        end
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
